// File: rtl/cond_eval_unit.sv
// Condition evaluation unit: owns the NZCV flag register and its save slot,
// and evaluates NUM_CH condition codes per cycle into a registered result pipeline.
module cond_eval_unit #(
  parameter int NUM_CH  = 2,
  parameter int BYPASS  = 1,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flag_we,
  input  logic [3:0]            flag_in,
  input  logic                  save,
  input  logic                  restore,
  input  logic                  stall,
  input  logic [NUM_CH-1:0]     q_valid,
  input  logic [4*NUM_CH-1:0]   q_code,
  output logic [NUM_CH-1:0]     r_valid,
  output logic [NUM_CH-1:0]     r_cond,
  output logic [3:0]            flags,
  output logic [3:0]            saved_flags
);

  logic [3:0]        flags_q;
  logic [3:0]        saved_q;
  logic [3:0]        eff;
  logic [NUM_CH-1:0] cond_now;
  logic [NUM_CH-1:0] vld_p0;
  logic [NUM_CH-1:0] cond_p0;

  function automatic logic cond_pass(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (code)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return c & !z;
      4'h9:    return !c | z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z & (n == v);
      4'hD:    return z | (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Restore outranks a flag write; save always captures the pre-update register,
  // which makes save+restore a swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      saved_q <= '0;
    end else begin
      if (restore)
        flags_q <= saved_q;
      else if (flag_we)
        flags_q <= flag_in;
      if (save)
        saved_q <= flags_q;
    end
  end

  assign flags       = flags_q;
  assign saved_flags = saved_q;

  always_comb begin
    eff = flags_q;
    if (BYPASS != 0) begin
      if (restore)
        eff = saved_q;
      else if (flag_we)
        eff = flag_in;
    end
  end

  always_comb begin
    cond_now = '0;
    for (int i = 0; i < NUM_CH; i++)
      cond_now[i] = q_valid[i] & cond_pass(q_code[4*i +: 4], eff);
  end

  // ---- stage p0: capture queries (held upstream while stalled) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= '0;
      cond_p0 <= '0;
    end else if (!stall) begin
      vld_p0  <= q_valid;
      cond_p0 <= cond_now;
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic [NUM_CH-1:0] vld_p1;
      logic [NUM_CH-1:0] cond_p1;

      // ---- stage p1: optional extra output register ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p1  <= '0;
          cond_p1 <= '0;
        end else if (!stall) begin
          vld_p1  <= vld_p0;
          cond_p1 <= cond_p0;
        end
      end

      assign r_valid = vld_p1;
      assign r_cond  = cond_p1;
    end else begin : g_lat1
      assign r_valid = vld_p0;
      assign r_cond  = cond_p0;
    end
  endgenerate

endmodule

// File: tb/tb_cond_eval_unit.sv
// Bench for cond_eval_unit: three configurations (bypass, no-bypass, 4-channel
// two-stage) driven in parallel and compared against a behavioural model.
module tb_cond_eval_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_we, save, restore, stall;
  logic [3:0]  flag_in;
  logic [1:0]  q_valid;
  logic [7:0]  q_code;
  logic [3:0]  q_valid4;
  logic [15:0] q_code4;

  logic [1:0]  rv_a, rc_a, rv_b, rc_b;
  logic [3:0]  fl_a, sf_a, fl_b, sf_b;
  logic [3:0]  rv_c, rc_c, fl_c, sf_c;

  int n_checks = 0;
  int n_errors = 0;

  bit [3:0] m_flags, m_saved;
  bit [1:0] m_v1, m_c1, m_cnb;
  bit [3:0] m_l2v [2];
  bit [3:0] m_l2c [2];

  always #5 clk = ~clk;

  cond_eval_unit #(.NUM_CH(2), .BYPASS(1), .LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in), .save(save),
    .restore(restore), .stall(stall), .q_valid(q_valid), .q_code(q_code),
    .r_valid(rv_a), .r_cond(rc_a), .flags(fl_a), .saved_flags(sf_a));

  cond_eval_unit #(.NUM_CH(2), .BYPASS(0), .LATENCY(1)) u_nb (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in), .save(save),
    .restore(restore), .stall(stall), .q_valid(q_valid), .q_code(q_code),
    .r_valid(rv_b), .r_cond(rc_b), .flags(fl_b), .saved_flags(sf_b));

  cond_eval_unit #(.NUM_CH(4), .BYPASS(1), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in), .save(save),
    .restore(restore), .stall(stall), .q_valid(q_valid4), .q_code(q_code4),
    .r_valid(rv_c), .r_cond(rc_c), .flags(fl_c), .saved_flags(sf_c));

  // ARM grouping: code[3:1] picks a base test, code[0] inverts it (AL inverts to NV).
  function automatic bit ref_cond(input bit [3:0] code, input bit [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("flags",      8'(fl_a), 8'(m_flags));
    check("saved",      8'(sf_a), 8'(m_saved));
    check("flags_nb",   8'(fl_b), 8'(m_flags));
    check("flags_l2",   8'(fl_c), 8'(m_flags));
    check("rvalid",     8'(rv_a), 8'(m_v1));
    check("rcond",      8'(rc_a), 8'(m_c1));
    check("rvalid_nb",  8'(rv_b), 8'(m_v1));
    check("rcond_nb",   8'(rc_b), 8'(m_cnb));
    check("rvalid_l2",  8'(rv_c), 8'(m_l2v[1]));
    check("rcond_l2",   8'(rc_c), 8'(m_l2c[1]));
  endtask

  task automatic model_reset();
    m_flags = '0; m_saved = '0; m_v1 = '0; m_c1 = '0; m_cnb = '0;
    m_l2v[0] = '0; m_l2v[1] = '0; m_l2c[0] = '0; m_l2c[1] = '0;
  endtask

  // One clock: predict from the inputs now applied, advance, then compare.
  task automatic step();
    bit [3:0] nf, ns, c4;
    bit [1:0] cb, cn;
    nf = restore ? m_saved : (flag_we ? flag_in : m_flags);
    ns = save ? m_flags : m_saved;
    for (int i = 0; i < 2; i++) begin
      cb[i] = q_valid[i] && ref_cond(q_code[4*i +: 4], nf);
      cn[i] = q_valid[i] && ref_cond(q_code[4*i +: 4], m_flags);
    end
    for (int i = 0; i < 4; i++)
      c4[i] = q_valid4[i] && ref_cond(q_code4[4*i +: 4], nf);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (!stall) begin
        m_v1 = q_valid; m_c1 = cb; m_cnb = cn;
        m_l2v[1] = m_l2v[0]; m_l2c[1] = m_l2c[0];
        m_l2v[0] = q_valid4; m_l2c[0] = c4;
      end
      m_flags = nf; m_saved = ns;
    end
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; flag_we = 0; flag_in = 0; save = 0; restore = 0; stall = 0;
    q_valid = 0; q_code = 0; q_valid4 = 0; q_code4 = 0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
    step();

    // Decode sweep over all flag values and codes on channel 0
    for (int f = 0; f < 16; f++) begin
      flag_we = 1; flag_in = 4'(f); q_valid = 0;
      step();
      flag_we = 0;
      for (int code = 0; code < 16; code++) begin
        q_valid = 2'b01; q_code = {4'h0, 4'(code)};
        step();
        if (code == 14) check("sweep_al", 8'(rc_a[0]), 8'd1);
        if (code == 15) check("sweep_nv", 8'(rc_a[0]), 8'd0);
      end
    end
    q_valid = 0;

    // Same-cycle bypass vs registered-only
    flag_we = 1; flag_in = 4'b0000;
    step();
    flag_in = 4'b0100; q_valid = 2'b01; q_code = 8'h00;
    step();
    check("bypass_eq",    8'(rc_a[0]), 8'd1);
    check("nobypass_eq",  8'(rc_b[0]), 8'd0);
    check("bypass_flags", 8'(fl_a), 8'h4);
    flag_we = 0; q_valid = 0;

    // Save/restore swap, then restore overriding a flag write
    flag_we = 1; flag_in = 4'b0011;
    step();
    flag_we = 0; save = 1;
    step();
    save = 0; flag_we = 1; flag_in = 4'b1000;
    step();
    flag_we = 0; save = 1; restore = 1;
    step();
    check("swap_flags", 8'(fl_a), 8'h3);
    check("swap_saved", 8'(sf_a), 8'h8);
    save = 0; restore = 1; flag_we = 1; flag_in = 4'b1111;
    step();
    check("restore_prio", 8'(fl_a), 8'h8);
    restore = 0; flag_we = 0;

    // Stall holds results
    q_valid = 2'b10; q_code = 8'hE0;
    step();
    stall = 1; q_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_rvalid", 8'(rv_a), 8'h2);
      check("stall_rcond",  8'(rc_a), 8'h2);
    end
    stall = 0;
    step();
    check("unstall_rvalid", 8'(rv_a), 8'h0);

    // Two-stage, four channel: GE/LT/GT/LE with N=V=1, Z=0
    flag_we = 1; flag_in = 4'b1001;
    step();
    flag_we = 0; q_valid4 = 4'hF; q_code4 = 16'hDCBA;
    step();
    q_valid4 = 4'h0;
    step();
    check("l2_rvalid", 8'(rv_c), 8'h0F);
    check("l2_rcond",  8'(rc_c), 8'h05);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      flag_we  = ($urandom_range(0, 2) == 0);
      flag_in  = 4'($urandom);
      save     = ($urandom_range(0, 4) == 0);
      restore  = ($urandom_range(0, 4) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      q_valid  = 2'($urandom);
      q_code   = 8'($urandom);
      q_valid4 = 4'($urandom);
      q_code4  = 16'($urandom);
      step();
    end
    flag_we = 0; save = 0; restore = 0; stall = 0; q_valid4 = 0;

    // Asynchronous reset between clock edges
    flag_we = 1; flag_in = 4'b0110; q_valid = 2'b11; q_code = 8'hEE;
    step();
    flag_we = 0;
    check("pre_rst_rvalid", 8'(rv_a), 8'h3);
    check("pre_rst_flags",  8'(fl_a), 8'h6);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    q_valid = 0;
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
